// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO controller for the MEM stage. It decodes the 0x8000_00xx window,
// returns registered load data, and drives the UART TX/RX valid/ready handshakes.
module mmio_io_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int unsigned DWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] addr,
  input  logic [3:0]        wbe,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic              stall,
  input  logic [DWIDTH-1:0] cycles,
  input  logic [DWIDTH-1:0] instret,
  input  logic              uart_tx_ready,
  output logic              uart_tx_valid,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_rx_ready,
  output logic              io_hit,
  output logic [DWIDTH-1:0] rdata
);

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RXDATA  = 8'h04;
  localparam logic [7:0] OFF_TXDATA  = 8'h08;
  localparam logic [7:0] OFF_CYCLES  = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

  tx_state_e         tx_state_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic [DWIDTH-1:0] rdata_q;
  logic [DWIDTH-1:0] rdata_d;
  logic              rx_ready_q;
  logic              rx_ready_d;

  logic [7:0]        offset_s;
  logic              win_hit_s;
  logic              store_s;
  logic              rd_eff_s;
  logic              wr_eff_s;
  logic              tx_load_s;
  logic              unused_wdata_s;

  assign offset_s       = addr[7:0];
  assign win_hit_s      = (addr[DWIDTH-1:8] == IO_BASE[DWIDTH-1:8]);
  assign store_s        = (wbe != 4'h0);
  assign io_hit         = win_hit_s & (re | store_s);
  // A store always takes priority over a load issued in the same cycle.
  assign rd_eff_s       = re & io_hit & ~stall & ~store_s;
  assign wr_eff_s       = store_s & io_hit & ~stall;
  assign tx_load_s      = wr_eff_s & wbe[0] & (offset_s == OFF_TXDATA);
  assign unused_wdata_s = ^wdata[DWIDTH-1:8];

  // Load data mux and RX pop pulse, both sampled at the edge of the effective read.
  always_comb begin
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    if (rd_eff_s) begin
      case (offset_s)
        OFF_STATUS:  rdata_d = {{(DWIDTH-2){1'b0}}, uart_rx_valid,
                                uart_tx_ready & (tx_state_q != TX_HOLD)};
        OFF_RXDATA: begin
          if (uart_rx_valid) begin
            rdata_d    = {{(DWIDTH-8){1'b0}}, uart_rx_data};
            rx_ready_d = 1'b1;
          end else begin
            rdata_d    = {DWIDTH{1'b0}};
            rx_ready_d = 1'b0;
          end
        end
        OFF_CYCLES:  rdata_d = cycles;
        OFF_INSTRET: rdata_d = instret;
        default:     rdata_d = {DWIDTH{1'b0}};
      endcase
    end else begin
      rdata_d    = rdata_q;
      rx_ready_d = 1'b0;
    end
  end

  // Load data and pop-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= {DWIDTH{1'b0}};
      rx_ready_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // TX hold FSM: while a byte is held, further writes are dropped until the handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_load_s) begin
            tx_state_q <= TX_HOLD;
            tx_valid_q <= 1'b1;
            tx_data_q  <= wdata[7:0];
          end
        end
        TX_HOLD: begin
          if (uart_tx_ready) begin
            tx_state_q <= TX_IDLE;
            tx_valid_q <= 1'b0;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdata         = rdata_q;
  assign uart_rx_ready = rx_ready_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: hand-computed expectations checked after each clock edge.
module tb_mmio_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic        re;
  logic        stall;
  logic [31:0] cycles;
  logic [31:0] instret;
  logic        uart_tx_ready;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_ready;
  logic        io_hit;
  logic [31:0] rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mmio_io_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .wbe(wbe), .wdata(wdata), .re(re),
    .stall(stall), .cycles(cycles), .instret(instret),
    .uart_tx_ready(uart_tx_ready), .uart_tx_valid(uart_tx_valid),
    .uart_tx_data(uart_tx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .io_hit(io_hit), .rdata(rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    re = 1'b0; wbe = 4'h0; wdata = 32'h0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = 32'h0; wbe = 4'h0; wdata = 32'h0; re = 1'b0; stall = 1'b0;
    cycles = 32'h0; instret = 32'h0; uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    tick();
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check_eq("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check_eq("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
    rst = 1'b0;

    // cycles load
    addr = 32'h8000_0010; re = 1'b1; cycles = 32'h0000_1234;
    #1;
    check_eq("io_hit_load", {31'b0, io_hit}, 32'h1);
    tick();
    check_eq("cycles_rdata", rdata, 32'h0000_1234);
    check_eq("cycles_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
    check_eq("cycles_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    idle_bus(); cycles = 32'h0000_9999;
    tick();
    check_eq("rdata_hold_idle", rdata, 32'h0000_1234);

    // RX pop
    uart_rx_valid = 1'b1; uart_rx_data = 8'hA5; addr = 32'h8000_0004; re = 1'b1;
    tick();
    check_eq("rx_rdata", rdata, 32'h0000_00A5);
    check_eq("rx_pulse", {31'b0, uart_rx_ready}, 32'h1);
    re = 1'b0;
    tick();
    check_eq("rx_pulse_end", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_valid = 1'b0; re = 1'b1;
    tick();
    check_eq("rx_empty_rdata", rdata, 32'h0);
    check_eq("rx_empty_nopulse", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h3C;
    tick();
    check_eq("rx_b2b_1", {31'b0, uart_rx_ready}, 32'h1);
    tick();
    check_eq("rx_b2b_2", {31'b0, uart_rx_ready}, 32'h1);
    uart_rx_valid = 1'b0;
    tick();
    check_eq("rx_b2b_stop", {31'b0, uart_rx_ready}, 32'h0);

    // store and load together: store wins, no pop
    uart_rx_valid = 1'b1; uart_rx_data = 8'h77; re = 1'b1; wbe = 4'h2; addr = 32'h8000_0004;
    tick();
    check_eq("wr_wins_nopop", {31'b0, uart_rx_ready}, 32'h0);
    check_eq("wr_wins_rdata", rdata, 32'h0);
    idle_bus(); uart_rx_valid = 1'b0;

    // TX hold
    uart_tx_ready = 1'b0; addr = 32'h8000_0008; wbe = 4'h1; wdata = 32'h0000_0041;
    tick();
    check_eq("tx_valid_set", {31'b0, uart_tx_valid}, 32'h1);
    check_eq("tx_data_41", {24'b0, uart_tx_data}, 32'h41);
    wdata = 32'h0000_0042;
    tick();
    check_eq("tx_drop_42", {24'b0, uart_tx_data}, 32'h41);
    wbe = 4'h0;
    tick();
    check_eq("tx_still_valid", {31'b0, uart_tx_valid}, 32'h1);
    addr = 32'h8000_0000; re = 1'b1; uart_tx_ready = 1'b1;
    tick();
    check_eq("status_hold", rdata, 32'h0);
    check_eq("tx_valid_done", {31'b0, uart_tx_valid}, 32'h0);
    tick();
    check_eq("status_idle", rdata, 32'h1);

    // write at handshake edge is dropped
    idle_bus(); uart_tx_ready = 1'b0; addr = 32'h8000_0008; wbe = 4'h1; wdata = 32'h0000_0050;
    tick();
    uart_tx_ready = 1'b1; wdata = 32'h0000_0043;
    tick();
    check_eq("tx_hs_write_drop", {31'b0, uart_tx_valid}, 32'h0);
    check_eq("tx_hs_data", {24'b0, uart_tx_data}, 32'h50);

    // stall blocks TX latch, but an in-flight handshake completes
    stall = 1'b1; wdata = 32'h0000_0044;
    tick();
    check_eq("stall_no_latch", {31'b0, uart_tx_valid}, 32'h0);
    stall = 1'b0; uart_tx_ready = 1'b0; wdata = 32'h0000_0055;
    tick();
    check_eq("tx_55_valid", {31'b0, uart_tx_valid}, 32'h1);
    wbe = 4'h0; stall = 1'b1; uart_tx_ready = 1'b1;
    tick();
    check_eq("stall_hs_done", {31'b0, uart_tx_valid}, 32'h0);

    // stalled instret load
    idle_bus(); uart_tx_ready = 1'b0;
    addr = 32'h8000_0014; re = 1'b1; stall = 1'b1; instret = 32'h0000_0077;
    tick();
    check_eq("stall_rdata_1", rdata, 32'h1);
    tick();
    check_eq("stall_rdata_2", rdata, 32'h1);
    stall = 1'b0;
    tick();
    check_eq("instret_rdata", rdata, 32'h0000_0077);
    instret = 32'h0000_0088;
    addr = 32'h8000_0004; uart_rx_valid = 1'b1; uart_rx_data = 8'h99; stall = 1'b1;
    tick();
    check_eq("stall_no_pop", {31'b0, uart_rx_ready}, 32'h0);
    check_eq("stall_rx_rdata", rdata, 32'h0000_0077);
    uart_rx_valid = 1'b0; stall = 1'b0;

    // unmapped and write-only offsets, out-of-window address
    addr = 32'h8000_0020;
    tick();
    check_eq("unmapped_rdata", rdata, 32'h0);
    addr = 32'h8000_0010; cycles = 32'h0000_CAFE;
    tick();
    check_eq("cycles_cafe", rdata, 32'h0000_CAFE);
    addr = 32'h8000_0018;
    tick();
    check_eq("ctr_reset_rdata", rdata, 32'h0);
    addr = 32'h8000_0010;
    tick();
    addr = 32'h4000_0010; cycles = 32'h0000_BEEF;
    #1;
    check_eq("io_hit_miss", {31'b0, io_hit}, 32'h0);
    tick();
    check_eq("miss_rdata_hold", rdata, 32'h0000_CAFE);

    // reset while holding a byte
    idle_bus(); uart_tx_ready = 1'b0; addr = 32'h8000_0008; wbe = 4'h1; wdata = 32'h0000_0066;
    tick();
    check_eq("tx_66_valid", {31'b0, uart_tx_valid}, 32'h1);
    rst = 1'b1; wbe = 4'h0; addr = 32'h8000_0010; re = 1'b1;
    tick();
    check_eq("rst_hold_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check_eq("rst_hold_rdata", rdata, 32'h0);
    check_eq("rst_hold_tx_data", {24'b0, uart_tx_data}, 32'h0);
    rst = 1'b0; idle_bus();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
